// File: rtl/pkt_buffer_pkg.sv
// Shared definitions for the packet buffer: default geometry and the
// receive/hold state encoding used by the control FSM.
package pkt_buffer_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } pkt_state_t;

endpackage

// File: rtl/pkt_buffer_ram.sv
// Byte storage for one packet: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module pkt_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Synchronous write and registered read (read-before-write on a collision).
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pkt_buffer.sv
// Single-packet buffer: captures one inbound packet, holds it for random
// byte loads by the filter datapath, and drops packets larger than the store.
module pkt_buffer
    import pkt_buffer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              iCLOCK,
    input  logic              iRESET,
    input  logic [DATA_W-1:0] iRX_DATA,
    input  logic              iRX_VALID,
    input  logic              iRX_LAST,
    output logic              oRX_READY,
    input  logic              iRD_REQ,
    input  logic [ADDR_W-1:0] iRD_ADDR,
    output logic [DATA_W-1:0] oRD_DATA,
    output logic              oRD_VALID,
    output logic              oRD_ERR,
    output logic [ADDR_W:0]   oPKT_LEN,
    output logic              oPKT_READY,
    input  logic              iPKT_RELEASE,
    output logic              oOVERFLOW
);

    // Pointer constants sized to the byte counter (one bit wider than an address).
    localparam logic [ADDR_W:0] PTR_ZERO = '0;
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};

    pkt_state_t        r_state;
    pkt_state_t        w_state_next;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   w_wr_ptr_next;
    logic [ADDR_W:0]   r_pkt_len;
    logic [ADDR_W:0]   w_pkt_len_next;
    logic              w_rx_ready;
    logic              w_accept;
    logic              w_we;
    logic              w_overflow;
    logic              w_rd_in_bounds;
    logic              r_rd_valid;
    logic              r_rd_err;
    logic [DATA_W-1:0] r_rd_hold;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] w_rd_data;

    // Ready is gated by reset so nothing is accepted while iRESET is high.
    assign w_rx_ready = !iRESET && (r_state != HOLD);
    assign w_accept   = iRX_VALID && w_rx_ready;

    // State, write pointer and held length; reset discards any partial packet.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state   <= IDLE;
            r_wr_ptr  <= PTR_ZERO;
            r_pkt_len <= PTR_ZERO;
        end else begin
            r_state   <= w_state_next;
            r_wr_ptr  <= w_wr_ptr_next;
            r_pkt_len <= w_pkt_len_next;
        end
    end

    // Next-state, pointer and write-enable decode; overflow pulses in the
    // same cycle the final byte of an oversized packet is consumed.
    always_comb begin
        w_state_next   = r_state;
        w_wr_ptr_next  = r_wr_ptr;
        w_pkt_len_next = r_pkt_len;
        w_we           = 1'b0;
        w_overflow     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_we          = 1'b1;
                    w_wr_ptr_next = PTR_ONE;
                    if (iRX_LAST) begin
                        w_state_next   = HOLD;
                        w_pkt_len_next = PTR_ONE;
                    end else begin
                        w_state_next = RECV;
                    end
                end
            end
            RECV: begin
                if (w_accept) begin
                    if (r_wr_ptr == PTR_FULL) begin
                        // Store already full: this byte cannot fit.
                        if (iRX_LAST) begin
                            w_state_next  = IDLE;
                            w_wr_ptr_next = PTR_ZERO;
                            w_overflow    = 1'b1;
                        end else begin
                            w_state_next = DROP;
                        end
                    end else begin
                        w_we          = 1'b1;
                        w_wr_ptr_next = r_wr_ptr + PTR_ONE;
                        if (iRX_LAST) begin
                            w_state_next   = HOLD;
                            w_pkt_len_next = r_wr_ptr + PTR_ONE;
                        end
                    end
                end
            end
            HOLD: begin
                if (iPKT_RELEASE) begin
                    w_state_next   = IDLE;
                    w_wr_ptr_next  = PTR_ZERO;
                    w_pkt_len_next = PTR_ZERO;
                end
            end
            DROP: begin
                if (w_accept && iRX_LAST) begin
                    w_state_next  = IDLE;
                    w_wr_ptr_next = PTR_ZERO;
                    w_overflow    = 1'b1;
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_wr_ptr_next = PTR_ZERO;
            end
        endcase
    end

    // A load is only serviced from a held packet and within its length;
    // it sees the packet as it stands this cycle, even if released now.
    assign w_rd_in_bounds = (r_state == HOLD) && ({1'b0, iRD_ADDR} < r_pkt_len);

    pkt_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (iCLOCK),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (iRX_DATA),
        .i_re    (iRD_REQ),
        .i_raddr (iRD_ADDR),
        .o_rdata (w_ram_q)
    );

    // Error loads return zero; between loads the last returned byte is held.
    assign w_rd_data = r_rd_valid ? (r_rd_err ? '0 : w_ram_q) : r_rd_hold;

    // Load response pipeline: one-cycle valid pulse plus held-data register.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_hold  <= '0;
        end else begin
            r_rd_valid <= iRD_REQ;
            r_rd_err   <= iRD_REQ && !w_rd_in_bounds;
            if (r_rd_valid) begin
                r_rd_hold <= w_rd_data;
            end
        end
    end

    assign oRX_READY  = w_rx_ready;
    assign oRD_DATA   = w_rd_data;
    assign oRD_VALID  = r_rd_valid;
    assign oRD_ERR    = r_rd_err;
    assign oPKT_LEN   = r_pkt_len;
    assign oPKT_READY = (r_state == HOLD);
    assign oOVERFLOW  = w_overflow;

endmodule

// File: tb/tb_pkt_buffer.sv
// Directed bench for pkt_buffer: small packet capture and loads, oversized
// packet drop, full-depth packet, load-with-release, async mid-packet reset.
module tb_pkt_buffer;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic              iCLOCK;
    logic              iRESET;
    logic [DATA_W-1:0] iRX_DATA;
    logic              iRX_VALID;
    logic              iRX_LAST;
    logic              oRX_READY;
    logic              iRD_REQ;
    logic [ADDR_W-1:0] iRD_ADDR;
    logic [DATA_W-1:0] oRD_DATA;
    logic              oRD_VALID;
    logic              oRD_ERR;
    logic [ADDR_W:0]   oPKT_LEN;
    logic              oPKT_READY;
    logic              iPKT_RELEASE;
    logic              oOVERFLOW;

    int checks   = 0;
    int failures = 0;

    pkt_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .iCLOCK       (iCLOCK),
        .iRESET       (iRESET),
        .iRX_DATA     (iRX_DATA),
        .iRX_VALID    (iRX_VALID),
        .iRX_LAST     (iRX_LAST),
        .oRX_READY    (oRX_READY),
        .iRD_REQ      (iRD_REQ),
        .iRD_ADDR     (iRD_ADDR),
        .oRD_DATA     (oRD_DATA),
        .oRD_VALID    (oRD_VALID),
        .oRD_ERR      (oRD_ERR),
        .oPKT_LEN     (oPKT_LEN),
        .oPKT_READY   (oPKT_READY),
        .iPKT_RELEASE (iPKT_RELEASE),
        .oOVERFLOW    (oOVERFLOW)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        iRX_VALID = 1'b1;
        iRX_DATA  = d;
        iRX_LAST  = last;
        tick();
        iRX_VALID = 1'b0;
        iRX_LAST  = 1'b0;
    endtask

    // n non-final bytes with data base, base+1, ...
    task automatic send_bytes(input int n, input logic [7:0] base);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i);
            send_byte(d, 1'b0);
        end
        $display("tx %0d bytes base=0x%02h", n, base);
    endtask

    // One load beat; iRD_REQ is left high so calls can run back-to-back.
    task automatic load(input logic [7:0] addr, input logic rel);
        iRD_REQ      = 1'b1;
        iRD_ADDR     = addr;
        iPKT_RELEASE = rel;
        tick();
        iPKT_RELEASE = 1'b0;
        $display("load addr=%0d rel=%0b -> valid=%0b data=0x%02h err=%0b",
                 addr, rel, oRD_VALID, oRD_DATA, oRD_ERR);
    endtask

    initial begin
        iRESET       = 1'b1;
        iRX_DATA     = '0;
        iRX_VALID    = 1'b0;
        iRX_LAST     = 1'b0;
        iRD_REQ      = 1'b0;
        iRD_ADDR     = '0;
        iPKT_RELEASE = 1'b0;

        // Reset values
        #3;
        chk("rst_rx_ready",  16'(oRX_READY), 16'd0);
        chk("rst_pkt_ready", 16'(oPKT_READY), 16'd0);
        chk("rst_pkt_len",   16'(oPKT_LEN), 16'd0);
        chk("rst_rd_valid",  16'(oRD_VALID), 16'd0);
        chk("rst_rd_data",   16'(oRD_DATA), 16'd0);
        chk("rst_overflow",  16'(oOVERFLOW), 16'd0);
        tick();
        tick();
        iRESET = 1'b0;
        #1;
        chk("post_rst_rx_ready", 16'(oRX_READY), 16'd1);

        // 4-byte packet
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        $display("tx 4-byte packet");
        chk("p4_pkt_ready", 16'(oPKT_READY), 16'd1);
        chk("p4_pkt_len",   16'(oPKT_LEN), 16'd4);
        chk("p4_rx_ready",  16'(oRX_READY), 16'd0);

        // Back-to-back loads at 0, 3, 4, then 2, then an idle cycle
        load(8'd0, 1'b0);
        chk("ld0_valid", 16'(oRD_VALID), 16'd1);
        chk("ld0_data",  16'(oRD_DATA), 16'h11);
        chk("ld0_err",   16'(oRD_ERR), 16'd0);
        load(8'd3, 1'b0);
        chk("ld3_valid", 16'(oRD_VALID), 16'd1);
        chk("ld3_data",  16'(oRD_DATA), 16'h44);
        chk("ld3_err",   16'(oRD_ERR), 16'd0);
        load(8'd4, 1'b0);
        chk("ld4_valid", 16'(oRD_VALID), 16'd1);
        chk("ld4_data",  16'(oRD_DATA), 16'h00);
        chk("ld4_err",   16'(oRD_ERR), 16'd1);
        load(8'd2, 1'b0);
        chk("ld2_data",  16'(oRD_DATA), 16'h33);
        chk("ld2_err",   16'(oRD_ERR), 16'd0);
        iRD_REQ = 1'b0;
        tick();
        chk("idle_valid",     16'(oRD_VALID), 16'd0);
        chk("idle_data_hold", 16'(oRD_DATA), 16'h33);

        // Load at 1 with release in the same cycle
        load(8'd1, 1'b1);
        iRD_REQ = 1'b0;
        chk("rel_ld_valid",   16'(oRD_VALID), 16'd1);
        chk("rel_ld_data",    16'(oRD_DATA), 16'h22);
        chk("rel_ld_err",     16'(oRD_ERR), 16'd0);
        chk("rel_pkt_ready",  16'(oPKT_READY), 16'd0);
        chk("rel_rx_ready",   16'(oRX_READY), 16'd1);
        chk("rel_pkt_len",    16'(oPKT_LEN), 16'd0);

        // Load outside HOLD errors out with zero data
        load(8'd0, 1'b0);
        iRD_REQ = 1'b0;
        chk("idle_ld_err",  16'(oRD_ERR), 16'd1);
        chk("idle_ld_data", 16'(oRD_DATA), 16'h00);

        // 257-byte packet: final byte overflows straight from RECV
        send_bytes(256, 8'h00);
        chk("p257_full_pkt_ready", 16'(oPKT_READY), 16'd0);
        chk("p257_full_rx_ready",  16'(oRX_READY), 16'd1);
        chk("p257_full_overflow",  16'(oOVERFLOW), 16'd0);
        iRX_VALID = 1'b1;
        iRX_DATA  = 8'hEE;
        iRX_LAST  = 1'b1;
        #1;
        chk("p257_last_overflow", 16'(oOVERFLOW), 16'd1);
        tick();
        iRX_VALID = 1'b0;
        iRX_LAST  = 1'b0;
        #1;
        chk("p257_after_overflow",  16'(oOVERFLOW), 16'd0);
        chk("p257_after_pkt_ready", 16'(oPKT_READY), 16'd0);
        chk("p257_after_rx_ready",  16'(oRX_READY), 16'd1);
        chk("p257_after_pkt_len",   16'(oPKT_LEN), 16'd0);

        // 258-byte packet: goes through DROP, overflow on the final byte
        send_bytes(257, 8'h40);
        chk("p258_drop_rx_ready",  16'(oRX_READY), 16'd1);
        chk("p258_drop_overflow",  16'(oOVERFLOW), 16'd0);
        chk("p258_drop_pkt_ready", 16'(oPKT_READY), 16'd0);
        iRX_VALID = 1'b1;
        iRX_DATA  = 8'hEF;
        iRX_LAST  = 1'b1;
        #1;
        chk("p258_last_overflow", 16'(oOVERFLOW), 16'd1);
        tick();
        iRX_VALID = 1'b0;
        iRX_LAST  = 1'b0;
        #1;
        chk("p258_after_overflow",  16'(oOVERFLOW), 16'd0);
        chk("p258_after_pkt_ready", 16'(oPKT_READY), 16'd0);

        // 256-byte packet fits exactly: byte i = 0x80 + i
        send_bytes(255, 8'h80);
        iRX_VALID = 1'b1;
        iRX_DATA  = 8'h7F;
        iRX_LAST  = 1'b1;
        #1;
        chk("p256_last_overflow", 16'(oOVERFLOW), 16'd0);
        tick();
        iRX_VALID = 1'b0;
        iRX_LAST  = 1'b0;
        chk("p256_pkt_ready", 16'(oPKT_READY), 16'd1);
        chk("p256_pkt_len",   16'(oPKT_LEN), 16'd256);
        load(8'd255, 1'b0);
        chk("p256_ld255_data", 16'(oRD_DATA), 16'h7F);
        chk("p256_ld255_err",  16'(oRD_ERR), 16'd0);
        load(8'd0, 1'b0);
        chk("p256_ld0_data", 16'(oRD_DATA), 16'h80);
        iRD_REQ      = 1'b0;
        iPKT_RELEASE = 1'b1;
        tick();
        iPKT_RELEASE = 1'b0;
        chk("p256_rel_pkt_ready", 16'(oPKT_READY), 16'd0);
        chk("p256_rel_data_hold", 16'(oRD_DATA), 16'h80);

        // Asynchronous reset after 2 bytes of a packet
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        chk("pre_rst_data_hold", 16'(oRD_DATA), 16'h80);
        #1;
        iRESET = 1'b1;
        #1;
        chk("arst_rx_ready",  16'(oRX_READY), 16'd0);
        chk("arst_rd_data",   16'(oRD_DATA), 16'd0);
        chk("arst_pkt_len",   16'(oPKT_LEN), 16'd0);
        chk("arst_pkt_ready", 16'(oPKT_READY), 16'd0);
        chk("arst_rd_valid",  16'(oRD_VALID), 16'd0);
        chk("arst_rd_err",    16'(oRD_ERR), 16'd0);
        tick();
        iRESET = 1'b0;
        #1;
        chk("arst_release_rx_ready", 16'(oRX_READY), 16'd1);
        send_byte(8'h5C, 1'b1);
        $display("tx 1-byte packet");
        chk("p1_pkt_ready", 16'(oPKT_READY), 16'd1);
        chk("p1_pkt_len",   16'(oPKT_LEN), 16'd1);
        load(8'd0, 1'b0);
        chk("p1_ld0_data", 16'(oRD_DATA), 16'h5C);
        chk("p1_ld0_err",  16'(oRD_ERR), 16'd0);
        load(8'd1, 1'b0);
        chk("p1_ld1_err",  16'(oRD_ERR), 16'd1);
        chk("p1_ld1_data", 16'(oRD_DATA), 16'h00);
        iRD_REQ = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
